multicycle_control: RTL

Sequencing controller for the multi-cycle build of the RV32 core: it replaces the single-cycle opcode decoder and steps the shared datapath (one ALU, one unified memory port) through FETCH, DECODE, EXEC, MEM and WB. It sits between the instruction register and the datapath muxes and enables, and handshakes with the memory port through `mem_ready`. It also counts retired instructions and flags illegal opcodes and memory timeouts.

---
 rtl/riscv_ctrl_pkg.sv | 33 +++
 rtl/multicycle_control_if.sv | 33 +++
 rtl/opcode_classifier.sv | 21 ++
 rtl/multicycle_control.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32 control path: opcodes, FSM states, opcode classes, ALU op codes.
// Included by both the multi-cycle sequencer and the single-cycle decoder.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory-port bundle: IR opcode, memory handshake, datapath strobes, retire count.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             ir_write;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             alu_src;
  logic [1:0]       aluop;
  logic             branch;
  logic             reg_write;
  logic             mem_to_reg;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
           alu_src, aluop, branch, reg_write, mem_to_reg, illegal, bus_err, instret
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
           alu_src, aluop, branch, reg_write, mem_to_reg, illegal, bus_err, instret
  );
endinterface

// File: rtl/opcode_classifier.sv
// Combinational map from the 7-bit RV32 major opcode to its instruction class.
module opcode_classifier
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OPC_R:      op_class = CLS_R;
      OPC_I:      op_class = CLS_I;
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_STORE:  op_class = CLS_STORE;
      OPC_BRANCH: op_class = CLS_BRANCH;
      default:    op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 sequencer: steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB,
// bounds memory waits with a timeout, and counts retired instructions.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  op_class_t        op_class;
  op_class_t        dec_class;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] instret_q;
  logic             in_access;
  logic             timeout;

  opcode_classifier u_classifier (
    .opcode   (bus.opcode),
    .op_class (dec_class)
  );

  assign in_access = (state == ST_FETCH) || (state == ST_MEM);
  assign timeout   = in_access && !bus.mem_ready && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // Every path into FETCH or MEM clears wait_cnt, so each access starts its own wait budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FETCH;
      op_class  <= CLS_ILLEGAL;
      wait_cnt  <= '0;
      instret_q <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            state <= ST_DECODE;
          end else if (timeout) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DECODE: begin
          op_class <= dec_class;
          wait_cnt <= '0;
          state    <= (dec_class == CLS_ILLEGAL) ? ST_FETCH : ST_EXEC;
        end
        ST_EXEC: begin
          wait_cnt <= '0;
          case (op_class)
            CLS_R, CLS_I:         state <= ST_WB;
            CLS_LOAD, CLS_STORE:  state <= ST_MEM;
            CLS_BRANCH: begin
              instret_q <= instret_q + 1'b1;
              state     <= ST_FETCH;
            end
            default:              state <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (bus.mem_ready) begin
            wait_cnt <= '0;
            if (op_class == CLS_LOAD) begin
              state <= ST_WB;
            end else begin
              instret_q <= instret_q + 1'b1;
              state     <= ST_FETCH;
            end
          end else if (timeout) begin
            wait_cnt <= '0;
            state    <= ST_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WB: begin
          instret_q <= instret_q + 1'b1;
          wait_cnt  <= '0;
          state     <= ST_FETCH;
        end
        default: begin
          wait_cnt <= '0;
          state    <= ST_FETCH;
        end
      endcase
    end
  end

  logic       pc_write_c, pc_write_cond_c, ir_write_c, iord_c, mem_read_c, mem_write_c;
  logic       alu_src_c, branch_c, reg_write_c, mem_to_reg_c, illegal_c, bus_err_c;
  logic [1:0] aluop_c;

  // Moore decode, blanked while rst is high so an abort kills strobes in the same cycle.
  // ir_write/pc_write are qualified by mem_ready because they load at the completing edge.
  always_comb begin
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    ir_write_c      = 1'b0;
    iord_c          = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    alu_src_c       = 1'b0;
    aluop_c         = ALUOP_ADD;
    branch_c        = 1'b0;
    reg_write_c     = 1'b0;
    mem_to_reg_c    = 1'b0;
    illegal_c       = 1'b0;
    bus_err_c       = 1'b0;
    if (!rst) begin
      bus_err_c = timeout;
      case (state)
        ST_FETCH: begin
          mem_read_c = 1'b1;
          ir_write_c = bus.mem_ready;
          pc_write_c = bus.mem_ready;
        end
        ST_DECODE: illegal_c = (dec_class == CLS_ILLEGAL);
        ST_EXEC: begin
          case (op_class)
            CLS_R:      aluop_c = ALUOP_RFUNCT;
            CLS_I: begin
              aluop_c   = ALUOP_IFUNCT;
              alu_src_c = 1'b1;
            end
            CLS_LOAD, CLS_STORE: begin
              aluop_c   = ALUOP_ADD;
              alu_src_c = 1'b1;
            end
            CLS_BRANCH: begin
              aluop_c         = ALUOP_SUB;
              branch_c        = 1'b1;
              pc_write_cond_c = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          iord_c      = 1'b1;
          mem_read_c  = (op_class == CLS_LOAD);
          mem_write_c = (op_class == CLS_STORE);
        end
        ST_WB: begin
          reg_write_c  = 1'b1;
          mem_to_reg_c = (op_class == CLS_LOAD);
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write      = pc_write_c;
  assign bus.pc_write_cond = pc_write_cond_c;
  assign bus.ir_write      = ir_write_c;
  assign bus.iord          = iord_c;
  assign bus.mem_read      = mem_read_c;
  assign bus.mem_write     = mem_write_c;
  assign bus.alu_src       = alu_src_c;
  assign bus.aluop         = aluop_c;
  assign bus.branch        = branch_c;
  assign bus.reg_write     = reg_write_c;
  assign bus.mem_to_reg    = mem_to_reg_c;
  assign bus.illegal       = illegal_c;
  assign bus.bus_err       = bus_err_c;
  assign bus.instret       = instret_q;

endmodule
